// File: rtl/boot_loader_ctrl.sv
// Boot loader: builds 16-bit words from UART bytes, writes them to IMEM from address 0, then releases the CPU.
// Optional trailer checksum (CSUM_LO/CSUM_HI states) is enabled by defining BOOT_CHECKSUM_EN.
module boot_loader_ctrl #(
    parameter int WORD_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  start_btn,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  cpu_rst,
    output logic                  cpu_run_en,
    output logic                  loading,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);
    localparam int              TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [3:0] {
        S_WAIT_CNT_LO,
        S_CNT_HI,
        S_LOAD_LO,
        S_LOAD_HI,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM_LO,
        S_CSUM_HI,
`endif
        S_DONE,
        S_RUN,
        S_ERROR
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t END_STATE = S_CSUM_LO;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t                  state_r, next_state_s;
    logic [7:0]              lo_byte_r;
    logic [15:0]             count_r;
    logic [TW-1:0]           timer_r;
    logic                    btn_prev_r, btn_rise_r;
    logic                    imem_we_r, cpu_rst_r, cpu_run_en_r, loading_r, load_error_r;
    logic [ADDR_WIDTH-1:0]   imem_waddr_r;
    logic [WORD_WIDTH-1:0]   imem_wdata_r;
    logic [15:0]             words_loaded_r;
    logic [15:0]             rx_word_s;
    logic                    commit_s, restart_s, timing_s, expire_s, last_s, cpu_pulse_s, loading_s;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0]             csum_r;
`endif

    // Next-state decode, word commit and timeout expiry
    always_comb begin
        next_state_s = state_r;
        commit_s     = 1'b0;
        restart_s    = 1'b0;
        rx_word_s    = {rx_byte, lo_byte_r};
        last_s       = ((words_loaded_r + 16'd1) == count_r);
        timing_s     = (state_r == S_CNT_HI) || (state_r == S_LOAD_LO) || (state_r == S_LOAD_HI)
`ifdef BOOT_CHECKSUM_EN
                       || (state_r == S_CSUM_LO) || (state_r == S_CSUM_HI)
`endif
                       ;
        expire_s     = timing_s && !rx_valid && (timer_r == T_LAST);
        case (state_r)
            S_WAIT_CNT_LO: begin
                if (rx_valid) next_state_s = S_CNT_HI;
                else          next_state_s = state_r;
            end
            S_CNT_HI: begin
                if (rx_valid) begin
                    if (rx_word_s == 16'h0000)                next_state_s = END_STATE;
                    else if ({1'b0, rx_word_s} > MAX_WORDS)   next_state_s = S_ERROR;
                    else                                      next_state_s = S_LOAD_LO;
                end else if (expire_s) begin
                    next_state_s = S_ERROR;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_LOAD_LO: begin
                if (rx_valid)      next_state_s = S_LOAD_HI;
                else if (expire_s) next_state_s = S_ERROR;
                else               next_state_s = state_r;
            end
            S_LOAD_HI: begin
                if (rx_valid) begin
                    commit_s     = 1'b1;
                    next_state_s = last_s ? END_STATE : S_LOAD_LO;
                end else if (expire_s) begin
                    next_state_s = S_ERROR;
                end else begin
                    next_state_s = state_r;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM_LO: begin
                if (rx_valid)      next_state_s = S_CSUM_HI;
                else if (expire_s) next_state_s = S_ERROR;
                else               next_state_s = state_r;
            end
            S_CSUM_HI: begin
                if (rx_valid)      next_state_s = (rx_word_s == csum_r) ? S_DONE : S_ERROR;
                else if (expire_s) next_state_s = S_ERROR;
                else               next_state_s = state_r;
            end
`endif
            S_DONE: begin
                if (btn_rise_r) next_state_s = S_RUN;
                else            next_state_s = state_r;
            end
            S_RUN: begin
                next_state_s = S_RUN;
            end
            S_ERROR: begin
                if (btn_rise_r) begin
                    next_state_s = S_WAIT_CNT_LO;
                    restart_s    = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = S_WAIT_CNT_LO;
        endcase
        cpu_pulse_s = (state_r == S_RUN) && btn_rise_r;
        loading_s   = (next_state_s != S_DONE) && (next_state_s != S_RUN) && (next_state_s != S_ERROR);
    end

    // State, byte staging, button edge detect and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r        <= S_WAIT_CNT_LO;
            lo_byte_r      <= 8'h00;
            count_r        <= 16'h0000;
            btn_prev_r     <= 1'b0;
            btn_rise_r     <= 1'b0;
            imem_we_r      <= 1'b0;
            imem_waddr_r   <= '0;
            imem_wdata_r   <= '0;
            words_loaded_r <= 16'h0000;
            cpu_rst_r      <= 1'b1;
            cpu_run_en_r   <= 1'b0;
            loading_r      <= 1'b1;
            load_error_r   <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            btn_prev_r <= start_btn;
            btn_rise_r <= start_btn & ~btn_prev_r;
            if (rx_valid) lo_byte_r <= rx_byte;
            if ((state_r == S_CNT_HI) && rx_valid) count_r <= rx_word_s;
            imem_we_r <= commit_s;
            if (commit_s) begin
                imem_waddr_r   <= words_loaded_r[ADDR_WIDTH-1:0];
                imem_wdata_r   <= rx_word_s;
                words_loaded_r <= words_loaded_r + 16'd1;
            end else if (restart_s) begin
                words_loaded_r <= 16'h0000;
            end
            cpu_rst_r    <= (next_state_s != S_RUN) || cpu_pulse_s;
            cpu_run_en_r <= (next_state_s == S_RUN) && !cpu_pulse_s;
            loading_r    <= loading_s;
            load_error_r <= (next_state_s == S_ERROR);
        end
    end

    // Inter-byte timeout: runs only while a frame is in progress
    always_ff @(posedge CLK) begin
        if (RESET || rx_valid || !timing_s || expire_s) timer_r <= '0;
        else                                            timer_r <= timer_r + 1'b1;
    end

`ifdef BOOT_CHECKSUM_EN
    // Running sum of data words, restarted for every new frame
    always_ff @(posedge CLK) begin
        if (RESET || (state_r == S_WAIT_CNT_LO)) csum_r <= 16'h0000;
        else if (commit_s)                        csum_r <= csum_r + rx_word_s;
    end
`endif

    assign imem_we      = imem_we_r;
    assign imem_waddr   = imem_waddr_r;
    assign imem_wdata   = imem_wdata_r;
    assign cpu_rst      = cpu_rst_r;
    assign cpu_run_en   = cpu_run_en_r;
    assign loading      = loading_r;
    assign load_error   = load_error_r;
    assign words_loaded = words_loaded_r;
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: random images against an array model of the expected IMEM.
module tb_boot_loader_ctrl;
    localparam int AW = 8;
    localparam int TO = 40;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic          start_btn = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [15:0]   imem_wdata;
    logic          cpu_rst, cpu_run_en, loading, load_error;
    logic [15:0]   words_loaded;

    int vectors = 0;
    int miscompares = 0;
    int we_count = 0;
    logic [15:0] mem_obs [0:255];
    logic [15:0] exp_mem [0:255];

    always #5 CLK = ~CLK;

    boot_loader_ctrl #(.WORD_WIDTH(16), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET), .rx_byte(rx_byte), .rx_valid(rx_valid), .start_btn(start_btn),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .cpu_run_en(cpu_run_en), .loading(loading),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    // Capture every IMEM write the DUT issues
    always @(posedge CLK) begin
        if (imem_we) begin
            mem_obs[imem_waddr] <= imem_wdata;
            we_count            <= we_count + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        tick(int'($urandom_range(0, 2)));
    endtask

    task automatic send_image(input int n);
        logic [15:0] sum;
        logic [15:0] cnt;
        sum = 16'h0000;
        cnt = 16'(n);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        for (int i = 0; i < n; i++) begin
            send_byte(exp_mem[i][7:0]);
            send_byte(exp_mem[i][15:8]);
            sum = sum + exp_mem[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(sum[7:0]);
        send_byte(sum[15:8]);
`endif
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        rx_valid  = 1'b0;
        start_btn = 1'b0;
        tick(2);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(3);
        vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", imem_we); end
        vectors++; if (imem_waddr !== 8'h00) begin miscompares++; $display("FAIL rst_waddr: got %h want 00", imem_waddr); end
        vectors++; if (imem_wdata !== 16'h0000) begin miscompares++; $display("FAIL rst_wdata: got %h want 0000", imem_wdata); end
        vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
        vectors++; if (cpu_run_en !== 1'b0) begin miscompares++; $display("FAIL rst_run_en: got %b want 0", cpu_run_en); end
        vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL rst_loading: got %b want 1", loading); end
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL rst_error: got %b want 0", load_error); end
        vectors++; if (words_loaded !== 16'h0000) begin miscompares++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
        RESET = 1'b0;
    endtask

    task automatic test_known_frame();
        int base;
        do_reset();
        base = we_count;
        exp_mem[0] = 16'h1234;
        exp_mem[1] = 16'hABCD;
        send_image(2);
        tick(2);
        vectors++; if (mem_obs[0] !== 16'h1234) begin miscompares++; $display("FAIL known_w0: got %h want 1234", mem_obs[0]); end
        vectors++; if (mem_obs[1] !== 16'hABCD) begin miscompares++; $display("FAIL known_w1: got %h want abcd", mem_obs[1]); end
        vectors++; if (we_count - base !== 2) begin miscompares++; $display("FAIL known_pulses: got %0d want 2", we_count - base); end
        vectors++; if (words_loaded !== 16'd2) begin miscompares++; $display("FAIL known_words: got %0d want 2", words_loaded); end
        vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL known_loading: got %b want 0", loading); end
        vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL known_cpu_rst: got %b want 1", cpu_rst); end
    endtask

    task automatic test_zero_and_run();
        int base;
        do_reset();
        base = we_count;
        send_image(0);
        tick(2);
        vectors++; if (we_count !== base) begin miscompares++; $display("FAIL zero_we: got %0d writes want 0", we_count - base); end
        vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL zero_loading: got %b want 0", loading); end
        start_btn = 1'b1;
        tick(1);
        vectors++; if (cpu_run_en !== 1'b0) begin miscompares++; $display("FAIL run_lat1: got %b want 0", cpu_run_en); end
        tick(1);
        vectors++; if (cpu_run_en !== 1'b1) begin miscompares++; $display("FAIL run_lat2: got %b want 1", cpu_run_en); end
        vectors++; if (cpu_rst !== 1'b0) begin miscompares++; $display("FAIL run_cpu_rst: got %b want 0", cpu_rst); end
        start_btn = 1'b0;
        tick(2);
        start_btn = 1'b1;
        tick(1);
        vectors++; if (cpu_rst !== 1'b0) begin miscompares++; $display("FAIL restart_c1: got %b want 0", cpu_rst); end
        tick(1);
        vectors++; if (cpu_rst !== 1'b1 || cpu_run_en !== 1'b0) begin miscompares++; $display("FAIL restart_c2: got rst=%b en=%b want 1/0", cpu_rst, cpu_run_en); end
        tick(1);
        vectors++; if (cpu_rst !== 1'b0 || cpu_run_en !== 1'b1) begin miscompares++; $display("FAIL restart_c3: got rst=%b en=%b want 0/1", cpu_rst, cpu_run_en); end
        start_btn = 1'b0;
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base = we_count;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h34);
        tick(TO - 3);
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b want 0", load_error); end
        tick(4);
        vectors++; if (load_error !== 1'b1) begin miscompares++; $display("FAIL to_error: got %b want 1", load_error); end
        vectors++; if (we_count !== base) begin miscompares++; $display("FAIL to_nowrite: got %0d writes want 0", we_count - base); end
        start_btn = 1'b1;
        tick(3);
        start_btn = 1'b0;
        vectors++; if (load_error !== 1'b0 || loading !== 1'b1) begin miscompares++; $display("FAIL to_recover: got err=%b ld=%b want 0/1", load_error, loading); end
        vectors++; if (words_loaded !== 16'd0) begin miscompares++; $display("FAIL to_words: got %0d want 0", words_loaded); end
        exp_mem[0] = 16'($urandom);
        send_image(1);
        tick(2);
        vectors++; if (mem_obs[0] !== exp_mem[0]) begin miscompares++; $display("FAIL to_reload: got %h want %h", mem_obs[0], exp_mem[0]); end
        vectors++; if (words_loaded !== 16'd1 || loading !== 1'b0) begin miscompares++; $display("FAIL to_reload_done: got words=%0d ld=%b want 1/0", words_loaded, loading); end
    endtask

    task automatic test_oversize();
        int base;
        logic [7:0] hi_tab [2];
        logic [7:0] lo_tab [2];
        lo_tab[0] = 8'h2D; hi_tab[0] = 8'h01;
        lo_tab[1] = 8'h01; hi_tab[1] = 8'h01;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            base = we_count;
            send_byte(lo_tab[k]);
            send_byte(hi_tab[k]);
            vectors++; if (load_error !== 1'b1) begin miscompares++; $display("FAIL oversize_err%0d: got %b want 1", k, load_error); end
            send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
            tick(2);
            vectors++; if (we_count !== base || load_error !== 1'b1) begin miscompares++; $display("FAIL oversize_nowrite%0d: got %0d writes err=%b want 0/1", k, we_count - base, load_error); end
        end
    endtask

    task automatic test_reset_midload();
        int base;
        do_reset();
        base = we_count;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD);
        RESET = 1'b1;
        tick(1);
        vectors++; if (imem_we !== 1'b0 || cpu_rst !== 1'b1 || cpu_run_en !== 1'b0) begin miscompares++; $display("FAIL mid_ctl: got we=%b rst=%b en=%b want 0/1/0", imem_we, cpu_rst, cpu_run_en); end
        vectors++; if (loading !== 1'b1 || load_error !== 1'b0 || words_loaded !== 16'd0) begin miscompares++; $display("FAIL mid_led: got ld=%b err=%b words=%0d want 1/0/0", loading, load_error, words_loaded); end
        vectors++; if (imem_waddr !== 8'h00 || imem_wdata !== 16'h0000) begin miscompares++; $display("FAIL mid_bus: got %h/%h want 00/0000", imem_waddr, imem_wdata); end
        RESET = 1'b0;
        vectors++; if (we_count - base !== 1) begin miscompares++; $display("FAIL mid_partial: got %0d writes want 1", we_count - base); end
        exp_mem[0] = 16'($urandom);
        send_image(1);
        tick(2);
        vectors++; if (mem_obs[0] !== exp_mem[0] || words_loaded !== 16'd1) begin miscompares++; $display("FAIL mid_fresh: got %h words=%0d want %h/1", mem_obs[0], words_loaded, exp_mem[0]); end
    endtask

    task automatic test_random_images();
        int n, base;
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? 256 : int'($urandom_range(1, 24));
            for (int i = 0; i < n; i++) exp_mem[i] = 16'($urandom);
            do_reset();
            base = we_count;
            send_image(n);
            tick(2);
            vectors++; if (words_loaded !== 16'(n)) begin miscompares++; $display("FAIL rand_words: got %0d want %0d", words_loaded, n); end
            vectors++; if (we_count - base !== n) begin miscompares++; $display("FAIL rand_pulses: got %0d want %0d", we_count - base, n); end
            vectors++; if (loading !== 1'b0 || load_error !== 1'b0) begin miscompares++; $display("FAIL rand_status: got ld=%b err=%b want 0/0", loading, load_error); end
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (mem_obs[i] !== exp_mem[i]) begin miscompares++; $display("FAIL rand_mem[%0d]: got %h want %h", i, mem_obs[i], exp_mem[i]); end
            end
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12); send_byte(8'h34); send_byte(8'h12);
        tick(2);
        vectors++; if (loading !== 1'b0 || load_error !== 1'b0) begin miscompares++; $display("FAIL csum_good: got ld=%b err=%b want 0/0", loading, load_error); end
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12); send_byte(8'h35); send_byte(8'h12);
        tick(2);
        vectors++; if (load_error !== 1'b1) begin miscompares++; $display("FAIL csum_bad: got %b want 1", load_error); end
    endtask
`endif

    initial begin
        test_reset();
        test_known_frame();
        test_zero_and_run();
        test_timeout();
        test_oversize();
        test_reset_midload();
        test_random_images();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
